// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WTHRU
    } state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_SETS       = 16;
    localparam int DEF_LINE_WORDS = 4;

    localparam int OFF_W = $clog2(DEF_LINE_WORDS);
    localparam int IDX_W = $clog2(DEF_SETS);
    localparam int TAG_W = DEF_ADDR_WIDTH - IDX_W - OFF_W - 2;

endpackage

// File: rtl/data_cache_if.sv
// Single-outstanding req/ack word bus between the cache (master) and backing memory (slave).
interface data_cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_ack_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface

// File: rtl/data_cache_ctrl.sv
// Cache controller: IDLE/REFILL/WTHRU sequencing, refill word counter and registered
// backing-memory request signals. Array writes are signalled to the parent as strobes.
module data_cache_ctrl
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          rd_en_i,
    input  logic                          wr_en_i,
    input  logic                          hit_i,
    input  logic [ADDR_WIDTH-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic                          mem_ack_i,
    output logic                          stall_o,
    output logic                          rd_hit_o,
    output logic                          wr_hit_o,
    output logic                          refill_start_o,
    output logic                          refill_we_o,
    output logic                          refill_last_o,
    output logic [$clog2(LINE_WORDS)-1:0] refill_word_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam logic [WORD_W-1:0]     LAST_WORD = WORD_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);

    state_e                state_q, state_d;
    logic [WORD_W-1:0]     cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_done_q, wr_done_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wr_done_d      = wr_done_q;
        stall_o        = 1'b1;
        rd_hit_o       = 1'b0;
        wr_hit_o       = 1'b0;
        refill_start_o = 1'b0;
        refill_we_o    = 1'b0;
        refill_last_o  = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o   = 1'b0;
                wr_done_d = 1'b0;
                // wr_done_q marks the retire cycle of a finished store, which is still held upstream
                if (wr_en_i && !wr_done_q) begin
                    stall_o  = 1'b1;
                    wr_hit_o = hit_i;
                    state_d  = WTHRU;
                    req_d    = 1'b1;
                    we_d     = 1'b1;
                    addr_d   = addr_i & WORD_MASK;
                    wdata_d  = wdata_i;
                end else if (rd_en_i && !wr_en_i) begin
                    if (hit_i) begin
                        rd_hit_o = 1'b1;
                    end else begin
                        stall_o        = 1'b1;
                        refill_start_o = 1'b1;
                        state_d        = REFILL;
                        cnt_d          = '0;
                        req_d          = 1'b1;
                        we_d           = 1'b0;
                        addr_d         = addr_i & LINE_MASK;
                    end
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    refill_we_o = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    addr_d      = addr_q + ADDR_WIDTH'(4);
                    if (cnt_q == LAST_WORD) begin
                        refill_last_o = 1'b1;
                        state_d       = IDLE;
                        req_d         = 1'b0;
                    end
                end
            end
            WTHRU: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    wr_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_done_q <= wr_done_d;
        end
    end

    assign refill_word_o = cnt_q;
    assign mem_req_o     = req_q;
    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the M stage and
// backing memory. Holds the tag/data/valid arrays and hit logic; sequencing lives in the controller.
module data_cache
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  rd_en_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  stall_o,
    data_cache_if.master          mem
);

    localparam int WORD_W   = $clog2(LINE_WORDS);
    localparam int SET_W    = $clog2(SETS);
    localparam int TAG_LSB  = WORD_W + SET_W + 2;
    localparam int TAG_BITS = ADDR_WIDTH - TAG_LSB;

    logic [WORD_W-1:0]       word_sel;
    logic [SET_W-1:0]        set_idx;
    logic [TAG_BITS-1:0]     addr_tag;
    logic                    hit;

    logic [DATA_WIDTH-1:0]   data_mem [SETS*LINE_WORDS];
    logic [TAG_BITS-1:0]     tag_mem  [SETS];
    logic [SETS-1:0]         valid_q, valid_d;

    logic                    rd_hit, wr_hit;
    logic                    refill_start, refill_we, refill_last;
    logic [WORD_W-1:0]       refill_word;
    logic                    data_we;
    logic [SET_W+WORD_W-1:0] data_waddr;
    logic [DATA_WIDTH-1:0]   data_wdata;

    logic                    req, we;
    logic [ADDR_WIDTH-1:0]   maddr;
    logic [DATA_WIDTH-1:0]   mwdata;

    assign word_sel = addr_i[WORD_W+1:2];
    assign set_idx  = addr_i[TAG_LSB-1:WORD_W+2];
    assign addr_tag = addr_i[ADDR_WIDTH-1:TAG_LSB];
    assign hit      = valid_q[set_idx] && (tag_mem[set_idx] == addr_tag);

    data_cache_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_ctrl (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .rd_en_i        (rd_en_i),
        .wr_en_i        (wr_en_i),
        .hit_i          (hit),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .mem_ack_i      (mem.mem_ack_i),
        .stall_o        (stall_o),
        .rd_hit_o       (rd_hit),
        .wr_hit_o       (wr_hit),
        .refill_start_o (refill_start),
        .refill_we_o    (refill_we),
        .refill_last_o  (refill_last),
        .refill_word_o  (refill_word),
        .mem_req_o      (req),
        .mem_we_o       (we),
        .mem_addr_o     (maddr),
        .mem_wdata_o    (mwdata)
    );

    assign mem.mem_req_o   = req;
    assign mem.mem_we_o    = we;
    assign mem.mem_addr_o  = maddr;
    assign mem.mem_wdata_o = mwdata;

    assign rdata_o = rd_hit ? data_mem[{set_idx, word_sel}] : '0;

    // Refill and store-hit writes never coincide: one happens in REFILL, the other in IDLE
    always_comb begin
        data_we    = refill_we | wr_hit;
        data_waddr = refill_we ? {set_idx, refill_word} : {set_idx, word_sel};
        data_wdata = refill_we ? mem.mem_rdata_i : wdata_i;
    end

    always_comb begin
        valid_d = valid_q;
        if (refill_start) valid_d[set_idx] = 1'b0;
        if (refill_last)  valid_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (data_we) data_mem[data_waddr] <= data_wdata;
        if (refill_last) tag_mem[set_idx] <= addr_tag;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) valid_q <= '0;
        else          valid_q <= valid_d;
    end

endmodule
